uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- UART receiver and command decoder for the robot drive link.
- Deserialises 8N1 frames, each carrying one drive command byte: bits [3:0] = move_cmd, bits [7:4] = speed_level, LSB first on the wire.
- Holds the last valid command on its outputs and forces stop if the link goes silent.
- Used on the robot/peer side of the link, and as the loopback checker for the command transmitter on the FPGA side.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50_000_000/115_200); must be >= 4.
- TIMEOUT_CLKS, 25_000_000, cycles without a good frame before forcing stop; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- uart_in  input  1  asynchronous serial line, idle high.
- move_cmd  output  4  last accepted movement code; 4'b1000 = stop.
- speed_level  output  4  last accepted speed level.
- cmd_valid  output  1  one-cycle pulse when a new command is latched.
- frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity when the optional feature is built in).
- cmd_err  output  1  one-cycle pulse when a well-formed frame carries an illegal move code.
- link_timeout  output  1  high while the watchdog has expired.

Behaviour:
- Reset values: move_cmd=4'b1000, speed_level=0, cmd_valid=0, frame_err=0, cmd_err=0, link_timeout=0. Reset also sets FSM=IDLE, all counters=0, and the synchroniser flops to 1.
- Input path: uart_in passes through a 2-flop synchroniser; all logic below uses the synchronised value rx.
- FSM states: IDLE, START, DATA, STOP, BREAK (plus PARITY when the optional feature is built in).
- IDLE: rx==0 -> START, clear bit counter.
- START: wait CLKS_PER_BIT/2 cycles (integer divide), then re-sample rx.
  - rx==0 -> DATA.
  - rx==1 (glitch) -> IDLE, no pulses.
- DATA: sample rx every CLKS_PER_BIT cycles, mid-bit, into shift register bit 0..7 (LSB first). After bit 7 -> STOP.
- STOP: sample at mid-bit.
  - rx==1: frame good. Next cycle, decode the byte and return to IDLE.
  - rx==0: frame_err pulses on the next cycle -> BREAK. Outputs unchanged.
- BREAK: wait until rx==1, then -> IDLE. A held-low line yields no further frames and no repeated errors.
- Decode of a good frame:
  - data[3:0] <= 4'b1000 (0000..1000): move_cmd<=data[3:0], speed_level<=data[7:4], cmd_valid=1 for one cycle.
  - data[3:0] in 1001..1111: cmd_err pulses; move_cmd and speed_level are unchanged; no cmd_valid.
- Latency: outputs update and cmd_valid asserts exactly 1 cycle after the stop-bit mid-sample.
- Back-to-back frames: a start bit arriving immediately after the stop-bit sample is accepted. IDLE is re-entered before the next falling edge can reach the mid-start check.
- Watchdog (TIMEOUT_CLKS>0):
  - Counter clears on every cmd_valid and otherwise increments, saturating at TIMEOUT_CLKS.
  - On reaching TIMEOUT_CLKS: move_cmd<=4'b1000, speed_level<=0, link_timeout<=1.
  - link_timeout holds until the next cmd_valid, which clears it in the same cycle the new command is latched.
  - frame_err and cmd_err frames do not reset the watchdog.
- Simultaneous events: if watchdog expiry and cmd_valid fall on the same cycle, the new command wins and link_timeout stays 0.
- Reset mid-frame: returns to IDLE next cycle; the partial frame is discarded; no pulses.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined: frames are 8E1. After DATA, a PARITY state samples one extra bit at mid-bit. If (^data)^parity != 0, frame_err pulses and the FSM goes to STOP-skip/BREAK handling identically to a bad stop bit. A good frame additionally requires a valid stop bit.
- When undefined: no PARITY state; frames are 8N1.

Test Plan:
- Sim with CLKS_PER_BIT=8, TIMEOUT_CLKS=1000.
- Reset then idle line -> move_cmd=4'b1000, speed_level=0, all pulses 0.
- Send byte 8'h52 -> cmd_valid single pulse 1 cycle after stop mid-sample; move_cmd=4'b0010, speed_level=4'd5.
- Send 8'h31 then 8'h73 back-to-back, no idle gap -> two cmd_valid pulses; final move_cmd=4'b0011, speed_level=4'd7.
- Send 8'h0C -> cmd_err pulse; outputs keep previous values; cmd_valid stays 0. Send 8'h04 with stop bit forced 0 -> frame_err pulse; line then held low 50 bit-times -> no further pulses.
- 3-cycle low glitch on uart_in -> no pulses, FSM returns to IDLE. After 1000 idle cycles following a good frame -> link_timeout=1, move_cmd=4'b1000, speed_level=0. Next 8'h20 -> link_timeout=0, move_cmd=4'b0000, speed_level=2.
- Assert rst during data bit 4 of 8'hFF -> no pulses, outputs return to reset values. The next full frame 8'h15 decodes normally.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// UART receiver and drive-command decoder with link watchdog.
// Define UART_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [3:0] move_cmd,
  output logic [3:0] speed_level,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       link_timeout
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned WdW  = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [WdW-1:0]  WdMax    = WdW'(TIMEOUT_CLKS);
  localparam logic [3:0]      MoveStop = 4'b1000;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      move_q, move_d;
  logic [3:0]      speed_q, speed_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            cerr_q, cerr_d;
  logic            to_q, to_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            rx_meta_q, rx_q;
  logic            good;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    move_d  = move_q;
    speed_d = speed_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cerr_d  = 1'b0;
    to_d    = to_q;
    wd_d    = wd_q;
    good    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if ((^shift_q) ^ rx_q) begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end else begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_q) begin
            good    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        if (rx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (good) begin
      if (shift_q[3:0] <= MoveStop) begin
        move_d  = shift_q[3:0];
        speed_d = shift_q[7:4];
        valid_d = 1'b1;
      end else begin
        cerr_d = 1'b1;
      end
    end

    // A fresh command always beats a watchdog expiry on the same cycle.
    if (TIMEOUT_CLKS > 0) begin
      if (valid_d) begin
        wd_d = '0;
        to_d = 1'b0;
      end else if (wd_q != WdMax) begin
        wd_d = wd_q + WdW'(1);
        if (wd_q == WdMax - WdW'(1)) begin
          move_d  = MoveStop;
          speed_d = 4'd0;
          to_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      move_q    <= MoveStop;
      speed_q   <= 4'd0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      cerr_q    <= 1'b0;
      to_q      <= 1'b0;
      wd_q      <= '0;
    end else begin
      rx_meta_q <= uart_in;
      rx_q      <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      move_q    <= move_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      cerr_q    <= cerr_d;
      to_q      <= to_d;
      wd_q      <= wd_d;
    end
  end

  assign move_cmd     = move_q;
  assign speed_level  = speed_q;
  assign cmd_valid    = valid_q;
  assign frame_err    = ferr_q;
  assign cmd_err      = cerr_q;
  assign link_timeout = to_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: frame-level model predicts every output on every cycle,
// plus literal spot checks after each directed scenario.
module tb_uart_cmd_rx;

  localparam int unsigned Cpb = 8;
  localparam int unsigned Tmo = 1000;
`ifdef UART_PARITY_EN
  localparam int unsigned NBits = 10;
`else
  localparam int unsigned NBits = 9;
`endif
  // Start edge -> result edge: 2 sync flops + 1 detect, half a bit, then NBits full bits.
  localparam int Off = 3 + Cpb / 2 + NBits * Cpb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_in = 1'b1;
  logic [3:0] move_cmd, speed_level;
  logic       cmd_valid, frame_err, cmd_err, link_timeout;

  uart_cmd_rx #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT_CLKS(Tmo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_in     (uart_in),
    .move_cmd    (move_cmd),
    .speed_level (speed_level),
    .cmd_valid   (cmd_valid),
    .frame_err   (frame_err),
    .cmd_err     (cmd_err),
    .link_timeout(link_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         kind;   // 0: stop bit good, 1: framing error
    logic [7:0] data;
  } ev_t;

  ev_t  evq[$];
  ev_t  ev;
  int   cyc = 0;
  bit   ready = 1'b0;
  logic [3:0] m_move, m_speed;
  logic m_valid, m_ferr, m_cerr, m_to;
  int   m_since;
  int   n_chk = 0, n_pass = 0;
  int   n_valid = 0, n_ferr = 0, n_cerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Frame-level model, advanced once per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_cerr  = 1'b0;
      if (rst) begin
        m_move  = 4'b1000;
        m_speed = 4'd0;
        m_to    = 1'b0;
        m_since = 0;
        evq.delete();
        ready = 1'b1;
      end else if (ready) begin
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          if (ev.kind == 1) m_ferr = 1'b1;
          else if (ev.data[3:0] <= 4'd8) begin
            m_move  = ev.data[3:0];
            m_speed = ev.data[7:4];
            m_valid = 1'b1;
          end else m_cerr = 1'b1;
        end
        if (m_valid) begin
          m_since = 0;
          m_to    = 1'b0;
        end else if (m_since < Tmo) begin
          m_since++;
          if (m_since == Tmo) begin
            m_move  = 4'b1000;
            m_speed = 4'd0;
            m_to    = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready) begin
        chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("cmd_err", 32'(cmd_err), 32'(m_cerr));
        chk("link_timeout", 32'(link_timeout), 32'(m_to));
        chk("move_cmd", 32'(move_cmd), 32'(m_move));
        chk("speed_level", 32'(speed_level), 32'(m_speed));
        if (cmd_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1) n_ferr++;
        if (cmd_err === 1'b1) n_cerr++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full frame; rst_bit >= 0 pulses rst mid-way through that wire bit.
  task automatic send(input logic [7:0] d, input logic stop_b, input int rst_bit);
    logic bits[NBits+1];
    ev_t  e;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_PARITY_EN
    bits[9] = ^d;
`endif
    bits[NBits] = stop_b;
    for (int i = 0; i <= NBits; i++) begin
      for (int j = 0; j < Cpb; j++) begin
        @(posedge clk);
        #1;
        if (i == 0 && j == 0) begin
          e.at   = cyc + Off;
          e.kind = stop_b ? 0 : 1;
          e.data = d;
          evq.push_back(e);
        end
        if (j == 0) uart_in = bits[i];
        rst = (i == rst_bit && j == Cpb / 2);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_move", 32'(move_cmd), 32'd8);
    chk("reset_speed", 32'(speed_level), 32'd0);
    chk("reset_pulses", 32'({cmd_valid, frame_err, cmd_err, link_timeout}), 32'd0);
    tick(20);

    send(8'h52, 1'b1, -1);
    tick(2);
    chk("h52_move", 32'(move_cmd), 32'd2);
    chk("h52_speed", 32'(speed_level), 32'd5);
    chk("h52_model_move", 32'(m_move), 32'd2);
    chk("h52_valid_count", n_valid, 1);

    send(8'h31, 1'b1, -1);
    send(8'h73, 1'b1, -1);
    tick(2);
    chk("b2b_valid_count", n_valid, 3);
    chk("b2b_move", 32'(move_cmd), 32'd3);
    chk("b2b_speed", 32'(speed_level), 32'd7);

    send(8'h0C, 1'b1, -1);
    tick(2);
    chk("h0c_cmd_err_count", n_cerr, 1);
    chk("h0c_valid_count", n_valid, 3);
    chk("h0c_move_kept", 32'(move_cmd), 32'd3);
    chk("h0c_speed_kept", 32'(speed_level), 32'd7);

    send(8'h04, 1'b0, -1);
    tick(50 * Cpb);
    uart_in = 1'b1;
    tick(20);
    chk("break_ferr_count", n_ferr, 1);
    chk("break_cerr_count", n_cerr, 1);
    chk("break_valid_count", n_valid, 3);

    uart_in = 1'b0;
    tick(3);
    uart_in = 1'b1;
    tick(20);
    chk("glitch_pulses", n_valid + n_ferr + n_cerr, 5);

    tick(1100);
    chk("timeout_flag", 32'(link_timeout), 32'd1);
    chk("timeout_move", 32'(move_cmd), 32'd8);
    chk("timeout_speed", 32'(speed_level), 32'd0);
    chk("timeout_model", 32'(m_to), 32'd1);

    send(8'h20, 1'b1, -1);
    tick(2);
    chk("h20_timeout_clear", 32'(link_timeout), 32'd0);
    chk("h20_move", 32'(move_cmd), 32'd0);
    chk("h20_speed", 32'(speed_level), 32'd2);

    send(8'hFF, 1'b1, 5);
    tick(2);
    chk("rst_mid_move", 32'(move_cmd), 32'd8);
    chk("rst_mid_speed", 32'(speed_level), 32'd0);
    chk("rst_mid_valid_count", n_valid, 4);
    chk("rst_mid_err_count", n_ferr + n_cerr, 2);
    tick(10);

    send(8'h15, 1'b1, -1);
    tick(2);
    chk("h15_move", 32'(move_cmd), 32'd5);
    chk("h15_speed", 32'(speed_level), 32'd1);
    chk("h15_valid_count", n_valid, 5);
    tick(5);
    chk("events_drained", evq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
